// File: rtl/tlb_op_unit_if.sv
// Bundle between the TLB op unit, the commit stage/CP0 and the shared TLB.
// The slave modport is the unit's view; master is the environment's view.
interface tlb_op_unit_if #(
  parameter int IDX_W = 4
);
  // TLB entry as exchanged with the shared TLB.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [15:0] page_mask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic             flush;
  logic [31:0]      cp0_index;
  logic [31:0]      cp0_entry_hi;
  logic [31:0]      cp0_entry_lo0;
  logic [31:0]      cp0_entry_lo1;
  logic [31:0]      cp0_page_mask;
  logic [31:0]      cp0_wired;
  logic             wired_we;
  logic [IDX_W-1:0] tlbrw_index;
  logic             tlbrw_we;
  tlb_entry_t       tlbrw_wdata;
  tlb_entry_t       tlbrw_rdata;
  logic [31:0]      tlbp_entry_hi;
  logic [31:0]      tlbp_index;
  logic             done_valid;
  logic [1:0]       done_op;
  logic [31:0]      done_index;
  tlb_entry_t       done_entry;
  logic [31:0]      cp0_random;

  modport slave (
    input  req_valid, req_op, flush, cp0_index, cp0_entry_hi, cp0_entry_lo0,
           cp0_entry_lo1, cp0_page_mask, cp0_wired, wired_we, tlbrw_rdata, tlbp_index,
    output req_ready, tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
           done_valid, done_op, done_index, done_entry, cp0_random
  );

  modport master (
    output req_valid, req_op, flush, cp0_index, cp0_entry_hi, cp0_entry_lo0,
           cp0_entry_lo1, cp0_page_mask, cp0_wired, wired_we, tlbrw_rdata, tlbp_index,
    input  req_ready, tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
           done_valid, done_op, done_index, done_entry, cp0_random
  );
endinterface

// File: rtl/tlb_op_unit.sv
// TLB op unit: sequences TLBR/TLBWI/TLBWR/TLBP from commit into the shared TLB,
// returns Index/entry for CP0 writeback and owns the CP0 Random counter.
// One request in flight; accept -> op cycle -> done pulse.
module tlb_op_unit #(
  parameter int TLB_ENTRIES_NUM = 16
) (
  input logic          clk,
  input logic          rst,
  tlb_op_unit_if.slave bus
);
  localparam int IDX_W = $clog2(TLB_ENTRIES_NUM);
  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES_NUM - 1);

  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_PROBE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [26:0]      hi_q;    // {VPN2, ASID}
  logic [15:0]      mask_q;
  logic [24:0]      lo0_q;   // {PFN, C, D, V}
  logic [24:0]      lo1_q;
  logic             g_q;
  logic [IDX_W-1:0] random_q;
  logic             accept;
  logic             wired_big;
  logic             random_wrap;

  assign accept      = (state_q == S_IDLE) && bus.req_valid && !bus.flush;
  // A Wired value beyond the table pins Random at the top entry.
  assign wired_big   = |bus.cp0_wired[31:IDX_W];
  assign random_wrap = bus.wired_we || wired_big || (random_q <= bus.cp0_wired[IDX_W-1:0]);

  assign bus.tlbrw_wdata = {hi_q, mask_q, g_q, lo0_q, lo1_q};
  assign bus.done_op     = op_q;
  assign bus.cp0_random  = {{(32 - IDX_W){1'b0}}, random_q};

  // Random counter: decrements every cycle, reloads to the top on Wired write or floor hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      random_q <= RAND_TOP;
    end else if (random_wrap) begin
      random_q <= RAND_TOP;
    end else begin
      random_q <= random_q - 1'b1;
    end
  end

  // Control state: FSM state and the op reported on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= bus.req_op;
      end
    end
  end

  // CP0 operand snapshot at accept; only the fields a TLB entry needs are kept.
  always_ff @(posedge clk) begin
    if (accept) begin
      hi_q   <= {bus.cp0_entry_hi[31:13], bus.cp0_entry_hi[7:0]};
      mask_q <= bus.cp0_page_mask[28:13];
      lo0_q  <= bus.cp0_entry_lo0[25:1];
      lo1_q  <= bus.cp0_entry_lo1[25:1];
      g_q    <= bus.cp0_entry_lo0[0] & bus.cp0_entry_lo1[0];
    end
  end

  // TLB-facing index and probe key, loaded at accept so they are valid in the op cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.tlbrw_index   <= '0;
      bus.tlbp_entry_hi <= '0;
    end else if (accept) begin
      if (bus.req_op == OP_TLBP) begin
        bus.tlbp_entry_hi <= bus.cp0_entry_hi;
      end else if (bus.req_op == OP_TLBWR) begin
        bus.tlbrw_index <= random_q;
      end else begin
        bus.tlbrw_index <= bus.cp0_index[IDX_W-1:0];
      end
    end
  end

  // Result capture at the end of the READ / PROBE cycle; held until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.done_index <= '0;
      bus.done_entry <= '0;
    end else begin
      if (state_q == S_READ) begin
        bus.done_entry <= bus.tlbrw_rdata;
      end
      if (state_q == S_PROBE) begin
        bus.done_index <= bus.tlbp_index;
      end
    end
  end

  // Next-state and per-state strobes; flush cancels completion and returns to IDLE.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.tlbrw_we  = 1'b0;
    bus.done_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (bus.req_op == OP_TLBR) begin
            state_d = S_READ;
          end else if (bus.req_op == OP_TLBP) begin
            state_d = S_PROBE;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_READ, S_PROBE: begin
        state_d = bus.flush ? S_IDLE : S_DONE;
      end
      S_WRITE: begin
        bus.tlbrw_we = 1'b1;
        state_d      = bus.flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        bus.done_valid = !bus.flush;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule
